// File: rtl/interp_step_reader_if.sv
// Output stream from the interpolator readout towards the equalizer buffer.
interface interp_step_reader_if #(
  parameter int OUT_W = 16
) ();
  logic                    valid;
  logic                    ready;
  logic signed [OUT_W-1:0] data;
  logic [2:0]              idx;

  modport master (output valid, output data, output idx, input ready);
  modport slave  (input valid, input data, input idx, output ready);
endinterface

// File: rtl/interp_step_reader.sv
// Snapshots a pilot base and the E/2E/5E step registers, then streams the six
// interpolated estimates base + k*E (k = 0..5), saturated to OUT_W bits.
module interp_step_reader #(
  parameter int REG1   = 17,
  parameter int REG2   = 18,
  parameter int REG3   = 19,
  parameter int BASE_W = 16,
  parameter int OUT_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic signed [BASE_W-1:0] i_base_in,
  input  logic signed [REG1-1:0]   i_reg_e,
  input  logic signed [REG2-1:0]   i_reg_2e,
  input  logic signed [REG3-1:0]   i_reg_5e,
  interp_step_reader_if.master     out_if,
  output logic                     o_busy,
  output logic                     o_done
);
  localparam int SUM_W = 21;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(64'sd1 <<< (OUT_W-1)));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   r_state, w_state_nxt;
  logic [2:0]               r_k;
  logic signed [BASE_W-1:0] r_base;
  logic signed [REG1-1:0]   r_e;
  logic signed [REG2-1:0]   r_2e;
  logic signed [REG3-1:0]   r_5e;
  logic                     r_valid;
  logic signed [OUT_W-1:0]  r_data;

  logic                     w_start_ok;
  logic                     w_xfer;
  logic [2:0]               w_k_nxt;
  logic signed [SUM_W-1:0]  w_e, w_2e, w_5e, w_inc, w_sum;

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [SUM_W-1:0] s);
    if (s > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (s < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                  return s[OUT_W-1:0];
  endfunction

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_start_ok  = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_xfer = r_valid && out_if.ready;
        if (w_xfer && r_k == 3'd5) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Increment for the sample that follows the one being accepted; shifts and
  // one add replace a multiplier.
  assign w_k_nxt = r_k + 3'd1;
  assign w_e     = SUM_W'(r_e);
  assign w_2e    = SUM_W'(r_2e);
  assign w_5e    = SUM_W'(r_5e);

  always_comb begin
    w_inc = '0;
    case (w_k_nxt)
      3'd1:    w_inc = w_e;
      3'd2:    w_inc = w_2e;
      3'd3:    w_inc = w_e + w_2e;
      3'd4:    w_inc = w_2e <<< 1;
      3'd5:    w_inc = w_5e;
      default: w_inc = '0;
    endcase
  end

  assign w_sum = SUM_W'(r_base) + w_inc;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_k     <= '0;
      r_base  <= '0;
      r_e     <= '0;
      r_2e    <= '0;
      r_5e    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_start_ok) begin
      r_base  <= i_base_in;
      r_e     <= i_reg_e;
      r_2e    <= i_reg_2e;
      r_5e    <= i_reg_5e;
      r_k     <= '0;
      r_valid <= 1'b1;
      r_data  <= sat(SUM_W'(i_base_in));
    end else if (w_xfer) begin
      if (r_k == 3'd5) begin
        r_valid <= 1'b0;
      end else begin
        r_k    <= w_k_nxt;
        r_data <= sat(w_sum);
      end
    end
  end

  assign out_if.valid = r_valid;
  assign out_if.data  = r_data;
  assign out_if.idx   = r_k;
  assign o_busy       = (r_state == S_RUN);
  assign o_done       = (r_state == S_DONE);
endmodule

// File: tb/tb_interp_step_reader.sv
// Directed bench for interp_step_reader: ramps, saturation, backpressure,
// start-while-busy and mid-segment reset.
module tb_interp_step_reader;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic signed [15:0] base_in = '0;
  logic signed [16:0] reg_e = '0;
  logic signed [17:0] reg_2e = '0;
  logic signed [18:0] reg_5e = '0;
  logic               busy, done;
  int                 checks = 0;
  int                 errors = 0;

  interp_step_reader_if #(.OUT_W(16)) out_if ();

  interp_step_reader #(.REG1(17), .REG2(18), .REG3(19), .BASE_W(16), .OUT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_in(base_in),
    .i_reg_e(reg_e), .i_reg_2e(reg_2e), .i_reg_5e(reg_5e),
    .out_if(out_if), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int b, input int e, input int e2, input int e5);
    base_in = 16'(b); reg_e = 17'(e); reg_2e = 18'(e2); reg_5e = 19'(e5);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; out_if.ready = 1'b1;
    #3;
    checks++;
    if (out_if.valid !== 1'b0 || out_if.data !== 16'sd0 || out_if.idx !== 3'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%0d idx=%0d busy=%b done=%b want all 0",
               out_if.valid, out_if.data, out_if.idx, busy, done);
    end
    // start held during reset must not launch a segment
    tick();
    checks++;
    if (out_if.valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_with_rst: valid=%b busy=%b want 0 0", out_if.valid, busy);
    end
    start = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_segment(input string name, input int b, input int e, input int e2,
                              input int e5, input int exp [6]);
    logic signed [15:0] want;
    out_if.ready = 1'b1;
    launch(b, e, e2, e5);
    for (int k = 0; k < 6; k++) begin
      want = 16'(exp[k]);
      checks++;
      if (out_if.valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
          out_if.idx !== 3'(k) || out_if.data !== want) begin
        errors++;
        $display("FAIL %s k%0d: valid=%b busy=%b done=%b idx=%0d data=%0d want 1 1 0 %0d %0d",
                 name, k, out_if.valid, busy, done, out_if.idx, out_if.data, k, want);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || out_if.valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b valid=%b busy=%b want 1 0 0",
               name, done, out_if.valid, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic test_backpressure();
    int exp [6] = '{100, 110, 120, 130, 140, 150};
    out_if.ready = 1'b1;
    launch(100, 10, 20, 50);
    tick(); tick();
    out_if.ready = 1'b0;
    reg_e = 17'sd999; reg_2e = 18'sd1998; reg_5e = 19'sd4995; base_in = 16'sd7;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if (out_if.valid !== 1'b1 || out_if.idx !== 3'd2 || out_if.data !== 16'sd120) begin
        errors++;
        $display("FAIL stall%0d: valid=%b idx=%0d data=%0d want 1 2 120",
                 s, out_if.valid, out_if.idx, out_if.data);
      end
    end
    out_if.ready = 1'b1;
    for (int k = 2; k < 6; k++) begin
      checks++;
      if (out_if.idx !== 3'(k) || out_if.data !== 16'(exp[k])) begin
        errors++;
        $display("FAIL bp_resume k%0d: idx=%0d data=%0d want %0d %0d",
                 k, out_if.idx, out_if.data, k, exp[k]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: done=%b want 1", done);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int exp [6] = '{100, 110, 120, 130, 140, 150};
    int ndone = 0;
    out_if.ready = 1'b1;
    launch(100, 10, 20, 50);
    for (int c = 0; c < 9; c++) begin
      // pulse start in RUN (c=2) and in the DONE cycle (c=6)
      start = (c == 2 || c == 6);
      base_in = 16'sd5000; reg_e = 17'sd1;
      if (c < 6) begin
        checks++;
        if (out_if.idx !== 3'(c) || out_if.data !== 16'(exp[c])) begin
          errors++;
          $display("FAIL busy_start k%0d: idx=%0d data=%0d want %0d %0d",
                   c, out_if.idx, out_if.data, c, exp[c]);
        end
      end
      if (done === 1'b1) ndone++;
      tick();
    end
    start = 1'b0;
    checks++;
    if (ndone != 1 || busy !== 1'b0 || out_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_end: dones=%0d busy=%b valid=%b want 1 0 0",
               ndone, busy, out_if.valid);
    end
  endtask

  task automatic test_reset_mid_op();
    int exp [6] = '{100, 110, 120, 130, 140, 150};
    int ndone = 0;
    out_if.ready = 1'b1;
    launch(100, 10, 20, 50);
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_if.valid !== 1'b0 || out_if.data !== 16'sd0 || out_if.idx !== 3'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b data=%0d idx=%0d busy=%b done=%b want all 0",
               out_if.valid, out_if.data, out_if.idx, busy, done);
    end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: dones=%0d want 0", ndone);
    end
    test_segment("after_reset", 100, 10, 20, 50, exp);
  endtask

  initial begin
    out_if.ready = 1'b0;
    test_reset();
    test_segment("ramp", 100, 10, 20, 50, '{100, 110, 120, 130, 140, 150});
    test_segment("negative", -50, -7, -14, -35, '{-50, -57, -64, -71, -78, -85});
    test_segment("sat_pos", 32000, 300, 600, 1500, '{32000, 32300, 32600, 32767, 32767, 32767});
    test_segment("sat_neg", -32000, -300, -600, -1500,
                 '{-32000, -32300, -32600, -32768, -32768, -32768});
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
